lif_sequencer: RTL and testbench

- Configures and sequences one LIF neuron datapath on the Tiny Tapeout pin budget.
- Accepts a fixed-order stream of 16-bit configuration words: E_REST, E_TAU, V_TH, then N_COEF V_O coefficients. Each word is {ui_in, uio_in} assembled upstream.
- Then enters RUN: it paces neuron updates with a periodic step strobe, samples the input current, and enforces a refractory window after each spike.
- Sits between the pin-level host interface and the neuron core; the neuron consumes all config outputs directly.

---
 rtl/lif_pkg.sv | 32 +++
 rtl/lif_step_timer.sv | 68 ++++++
 rtl/lif_sequencer.sv | 149 ++++++++++++++
 tb/tb_lif_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lif_pkg
// Description : Shared types and constants for the LIF neuron sequencer:
//               sequencer state encoding, config word slot indices and
//               default widths/parameters.
// Revision    : 1.0 - initial release
// ============================================================================
package lif_pkg;

  // Sequencer states: loading configuration words, or pacing the neuron
  typedef enum logic [0:0] {
    LOAD = 1'b0,
    RUN  = 1'b1
  } lif_state_t;

  // Slot of each configuration word in the load stream
  localparam int IDX_EREST = 0;
  localparam int IDX_ETAU  = 1;
  localparam int IDX_VTH   = 2;
  localparam int IDX_COEF0 = 3;

  // Default widths and timing parameters
  localparam int LIF_W        = 16;
  localparam int LIF_N_COEF   = 9;
  localparam int LIF_STEP_DIV = 4;
  localparam int LIF_REFRACT  = 2;
  localparam int LIF_I_W      = 8;
  localparam int LIF_CNT_W    = 16;

endpackage
`default_nettype wire

// File: rtl/lif_step_timer.sv
`default_nettype none
// ============================================================================
// Module      : lif_step_timer
// Description : Divides the clock into neuron update steps and tracks the
//               post-spike refractory window. step_fire marks the edge on
//               which step_en will be registered high; refr_active tells the
//               caller that the current sampled on that edge must be zero.
// Revision    : 1.0 - initial release
// ============================================================================
module lif_step_timer
  import lif_pkg::*;
#(
  parameter int STEP_DIV = LIF_STEP_DIV,
  parameter int REFRACT  = LIF_REFRACT
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  input  logic spike_in,
  output logic step_en,
  output logic step_fire,
  output logic refr_active
);

  localparam logic [7:0] c_step_last = 8'(STEP_DIV - 1);
  localparam logic [7:0] c_refract   = 8'(REFRACT);

  logic [7:0] r_step_cnt;
  logic [7:0] r_refr_cnt;
  logic       r_step_en;

  // A step happens when the divider sits on its last count; a same-edge
  // spike also forces zero current because its refractory load wins.
  assign step_fire   = run && !clear && (r_step_cnt == c_step_last);
  assign refr_active = (r_refr_cnt != 8'd0) ||
                       (run && spike_in && (c_refract != 8'd0));
  assign step_en     = r_step_en;

  // Step divider and registered strobe; held at zero outside RUN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_step_cnt <= 8'd0;
      r_step_en  <= 1'b0;
    end else if (clear || !run) begin
      r_step_cnt <= 8'd0;
      r_step_en  <= 1'b0;
    end else begin
      r_step_en  <= step_fire;
      r_step_cnt <= step_fire ? 8'd0 : r_step_cnt + 8'd1;
    end
  end

  // Refractory counter: spike reloads it, each step consumes one count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_refr_cnt <= 8'd0;
    end else if (clear) begin
      r_refr_cnt <= 8'd0;
    end else if (run && spike_in) begin
      r_refr_cnt <= c_refract;
    end else if (step_fire && (r_refr_cnt != 8'd0)) begin
      r_refr_cnt <= r_refr_cnt - 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lif_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lif_sequencer
// Description : Loads the LIF neuron configuration from a fixed-order word
//               stream (E_REST, E_TAU, V_TH, N_COEF coefficients), then runs
//               the neuron with a periodic step strobe, per-step input
//               current sampling and a post-spike refractory window.
//               Optional spike counter enabled by macro LIF_SPIKE_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module lif_sequencer
  import lif_pkg::*;
#(
  parameter int W        = LIF_W,
  parameter int N_COEF   = LIF_N_COEF,
  parameter int STEP_DIV = LIF_STEP_DIV,
  parameter int REFRACT  = LIF_REFRACT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  input  logic [W-1:0]          cfg_word,
  output logic                  cfg_ready,
  input  logic                  cfg_clear,
  output logic [W-1:0]          e_rest,
  output logic [W-1:0]          e_tau,
  output logic [W-1:0]          v_th,
  output logic [N_COEF*W-1:0]   coef,
  output logic                  cfg_done,
  input  logic [LIF_I_W-1:0]    i_in,
  output logic [LIF_I_W-1:0]    i_out,
  output logic                  step_en,
  input  logic                  spike_in,
  output logic [LIF_CNT_W-1:0]  spike_cnt
);

  localparam int             IDXW       = $clog2(N_COEF + 3);
  localparam logic [IDXW-1:0] c_idx_last = IDXW'(IDX_COEF0 + N_COEF - 1);

  lif_state_t          r_state;
  lif_state_t          w_state_nxt;
  logic [IDXW-1:0]     r_idx;
  logic [W-1:0]        r_e_rest;
  logic [W-1:0]        r_e_tau;
  logic [W-1:0]        r_v_th;
  logic [W-1:0]        r_coef [N_COEF];
  logic [LIF_I_W-1:0]  r_i_out;
  logic                w_accept;
  logic                w_run;
  logic                w_step_fire;
  logic                w_refr_active;

  // A word dropped together with cfg_clear is never written anywhere
  assign w_accept  = cfg_valid && (r_state == LOAD) && !cfg_clear;
  assign w_run     = (r_state == RUN);
  assign cfg_ready = (r_state == LOAD);
  assign cfg_done  = w_run;

  assign e_rest = r_e_rest;
  assign e_tau  = r_e_tau;
  assign v_th   = r_v_th;
  assign i_out  = r_i_out;

  for (genvar k = 0; k < N_COEF; k++) begin : g_coef_out
    assign coef[k*W +: W] = r_coef[k];
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= LOAD;
    else      r_state <= w_state_nxt;
  end

  // Next state: clear always returns to LOAD; the last word enters RUN
  always_comb begin
    w_state_nxt = r_state;
    if (cfg_clear) begin
      w_state_nxt = LOAD;
    end else if (w_accept && (r_idx == c_idx_last)) begin
      w_state_nxt = RUN;
    end
  end

  // Word slot index advances on every accepted word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_idx <= '0;
    else if (cfg_clear) r_idx <= '0;
    else if (w_accept)  r_idx <= r_idx + 1'b1;
  end

  // Config register file; clear keeps the old values until overwritten
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_e_rest <= '0;
      r_e_tau  <= '0;
      r_v_th   <= '0;
      for (int k = 0; k < N_COEF; k++) r_coef[k] <= '0;
    end else if (w_accept) begin
      if (r_idx == IDXW'(IDX_EREST)) r_e_rest <= cfg_word;
      if (r_idx == IDXW'(IDX_ETAU))  r_e_tau  <= cfg_word;
      if (r_idx == IDXW'(IDX_VTH))   r_v_th   <= cfg_word;
      for (int k = 0; k < N_COEF; k++) begin
        if (r_idx == IDXW'(IDX_COEF0 + k)) r_coef[k] <= cfg_word;
      end
    end
  end

  lif_step_timer #(
    .STEP_DIV (STEP_DIV),
    .REFRACT  (REFRACT)
  ) u_step_timer (
    .clk         (clk),
    .rst         (rst),
    .run         (w_run),
    .clear       (cfg_clear),
    .spike_in    (spike_in),
    .step_en     (step_en),
    .step_fire   (w_step_fire),
    .refr_active (w_refr_active)
  );

  // Current sample taken on each step edge, gated by the refractory window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             r_i_out <= '0;
    else if (cfg_clear)   r_i_out <= '0;
    else if (w_step_fire) r_i_out <= w_refr_active ? '0 : i_in;
  end

`ifdef LIF_SPIKE_COUNT_EN
  logic [LIF_CNT_W-1:0] r_spike_cnt;

  // Saturating count of spike cycles seen while running
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_spike_cnt <= '0;
    end else if (cfg_clear) begin
      r_spike_cnt <= '0;
    end else if (w_run && spike_in && (r_spike_cnt != {LIF_CNT_W{1'b1}})) begin
      r_spike_cnt <= r_spike_cnt + 1'b1;
    end
  end

  assign spike_cnt = r_spike_cnt;
`else
  assign spike_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lif_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lif_sequencer
// Description : Self-checking bench for lif_sequencer. Expected i_out values
//               are queued by the stimulus and popped by a monitor on every
//               step_en pulse; configuration and control outputs are checked
//               directly against hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lif_sequencer;

  logic          clk;
  logic          rst;
  logic          cfg_valid;
  logic [15:0]   cfg_word;
  logic          cfg_ready;
  logic          cfg_clear;
  logic [15:0]   e_rest;
  logic [15:0]   e_tau;
  logic [15:0]   v_th;
  logic [143:0]  coef;
  logic          cfg_done;
  logic [7:0]    i_in;
  logic [7:0]    i_out;
  logic          step_en;
  logic          spike_in;
  logic [15:0]   spike_cnt;

  int            checks   = 0;
  int            failures = 0;
  logic [7:0]    exp_q[$];
  int            cyc       = 0;
  int            last_step = -1;
  logic [15:0]   words [12] = '{16'hC5FF, 16'h018E, 16'h3C00,
                                16'h0101, 16'h0201, 16'h0302, 16'h0501,
                                16'h0601, 16'h0701, 16'h0801, 16'h1001,
                                16'hE001};

  lif_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_word  (cfg_word),
    .cfg_ready (cfg_ready),
    .cfg_clear (cfg_clear),
    .e_rest    (e_rest),
    .e_tau     (e_tau),
    .v_th      (v_th),
    .coef      (coef),
    .cfg_done  (cfg_done),
    .i_in      (i_in),
    .i_out     (i_out),
    .step_en   (step_en),
    .spike_in  (spike_in),
    .spike_cnt (spike_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every step pulse pops one expected current and checks spacing
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (cfg_done !== 1'b1) last_step = -1;
      if (step_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_step: actual i_out=%h required no step", i_out);
        end else begin
          e = exp_q.pop_front();
          check("i_out_step", {24'd0, i_out}, {24'd0, e});
        end
        if (last_step >= 0) check("step_period", cyc - last_step, 4);
        last_step = cyc;
      end
    end
  end

  task automatic send_word(input logic [15:0] w);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_word  = w;
    @(posedge clk);
  endtask

  // Full 12-word load; ends on the negedge after the RUN-entry edge
  task automatic load_all(input logic [15:0] first);
    for (int i = 0; i < 12; i++) begin
      send_word(i == 0 ? first : words[i]);
      if (i == 10) begin
        #1 check("done_before_last", {31'd0, cfg_done}, 0);
      end
      if (i == 11) begin
        #1 check("done_after_last", {31'd0, cfg_done}, 1);
        check("ready_in_run", {31'd0, cfg_ready}, 0);
      end
    end
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // Advance to the next negedge showing step_en, bounded
  task automatic wait_step(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (step_en !== 1'b1 && n < 50);
    if (step_en !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL step_timeout: actual no step in %0d cycles required a step", n);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [15:0] exp_spk;
`ifdef LIF_SPIKE_COUNT_EN
    exp_spk = 16'd3;
`else
    exp_spk = 16'd0;
`endif
    rst = 1'b0; cfg_valid = 1'b0; cfg_word = 16'h0; cfg_clear = 1'b0;
    spike_in = 1'b0; i_in = 8'h28;
    repeat (2) @(negedge clk);
    check("rst_ready",  {31'd0, cfg_ready}, 1);
    check("rst_done",   {31'd0, cfg_done}, 0);
    check("rst_e_rest", {16'd0, e_rest}, 0);
    check("rst_coef",   {31'd0, |coef}, 0);
    check("rst_i_out",  {24'd0, i_out}, 0);
    check("rst_step",   {31'd0, step_en}, 0);
    rst = 1'b1;

    // Initial load and plain stepping
    load_all(16'hC5FF);
    check("e_rest", {16'd0, e_rest}, 32'hC5FF);
    check("e_tau",  {16'd0, e_tau},  32'h018E);
    check("v_th",   {16'd0, v_th},   32'h3C00);
    check("coef0",  {16'd0, coef[0 +: 16]},   32'h0101);
    check("coef4",  {16'd0, coef[64 +: 16]},  32'h0601);
    check("coef8",  {16'd0, coef[128 +: 16]}, 32'hE001);
    exp_q.push_back(8'h28);
    wait_step(n);
    check("first_step_latency", n, 4);
    exp_q.push_back(8'h28); wait_step(n);
    exp_q.push_back(8'h28); wait_step(n);

    // One spike: two zero-current steps, then the new current
    i_in = 8'h88; spike_in = 1'b1;
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h88);
    @(negedge clk); spike_in = 1'b0;
    repeat (3) wait_step(n);

    // Two more spikes; the later one restarts the window
    spike_in = 1'b1;
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h88);
    @(negedge clk); spike_in = 1'b0;
    @(negedge clk); spike_in = 1'b1;
    @(negedge clk); spike_in = 1'b0;
    repeat (3) wait_step(n);
    check("spike_cnt", {16'd0, spike_cnt}, {16'd0, exp_spk});

    // Config words ignored in RUN
    cfg_valid = 1'b1; cfg_word = 16'hBEEF;
    @(negedge clk); cfg_valid = 1'b0;
    check("run_ignores_word", {16'd0, e_rest}, 32'hC5FF);

    // Clear during RUN
    cfg_clear = 1'b1;
    @(negedge clk); cfg_clear = 1'b0;
    check("clr_done",   {31'd0, cfg_done}, 0);
    check("clr_ready",  {31'd0, cfg_ready}, 1);
    check("clr_step",   {31'd0, step_en}, 0);
    check("clr_i_out",  {24'd0, i_out}, 0);
    check("clr_e_rest", {16'd0, e_rest}, 32'hC5FF);
    check("clr_spike_cnt", {16'd0, spike_cnt}, 0);
    repeat (6) @(negedge clk);
    check("load_stays", {31'd0, cfg_done}, 0);

    // Word offered with clear is dropped, then a full reload
    cfg_clear = 1'b1; cfg_valid = 1'b1; cfg_word = 16'hDEAD;
    @(negedge clk); cfg_clear = 1'b0; cfg_valid = 1'b0;
    check("drop_with_clear", {16'd0, e_rest}, 32'hC5FF);
    load_all(16'hA5A5);
    check("reload_e_rest", {16'd0, e_rest}, 32'hA5A5);
    check("reload_e_tau",  {16'd0, e_tau},  32'h018E);
    check("reload_coef8",  {16'd0, coef[128 +: 16]}, 32'hE001);
    i_in = 8'h28;
    exp_q.push_back(8'h28);
    wait_step(n);
    check("reload_step_latency", n, 4);

    // Asynchronous reset in the middle of a load
    cfg_clear = 1'b1;
    @(negedge clk); cfg_clear = 1'b0;
    send_word(16'h7777);
    for (int i = 1; i < 5; i++) send_word(words[i]);
    #1 cfg_valid = 1'b0; rst = 1'b0;
    #1;
    check("arst_e_rest", {16'd0, e_rest}, 0);
    check("arst_e_tau",  {16'd0, e_tau}, 0);
    check("arst_v_th",   {16'd0, v_th}, 0);
    check("arst_coef",   {31'd0, |coef}, 0);
    check("arst_done",   {31'd0, cfg_done}, 0);
    check("arst_ready",  {31'd0, cfg_ready}, 1);
    @(negedge clk); rst = 1'b1;
    load_all(16'h1357);
    check("fresh_e_rest", {16'd0, e_rest}, 32'h1357);
    check("fresh_coef1",  {16'd0, coef[16 +: 16]}, 32'h0201);
    exp_q.push_back(8'h28);
    wait_step(n);
    check("fresh_step_latency", n, 4);

    repeat (2) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
